// File: rtl/registro_pkg.sv
// Shared constants and helpers for the registro_fifo key/data buffer.
package registro_pkg;

    localparam int MODE_DROP      = 0;
    localparam int MODE_OVERWRITE = 1;

    // Ceiling log2; clog2(1) = 0. Used for pointer and count widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/registro_fifo_if.sv
// Push/pop handshake and status bundle for registro_fifo.
interface registro_fifo_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) ();
    import registro_pkg::*;

    localparam int CW = clog2(DEPTH + 1);

    logic             wr;
    logic [WIDTH-1:0] d;
    logic             rd;
    logic [WIDTH-1:0] q;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;

    modport master (
        output wr, d, rd,
        input  q, empty, full, count
    );

    modport slave (
        input  wr, d, rd,
        output q, empty, full, count
    );

endinterface

// File: rtl/registro_n.sv
// WIDTH-bit storage register with load enable; contents are not reset.
module registro_n #(
    parameter int WIDTH = 4
) (
    input  logic             ck,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load on enable, hold otherwise.
    always_ff @(posedge ck) begin
        if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/registro_fifo.sv
// Keyboard-path key/data buffer: DEPTH x WIDTH FIFO, first-word-fall-through,
// with drop or overwrite-oldest policy when full and sticky ovf/unf flags.
module registro_fifo
    import registro_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int MODE  = MODE_DROP
) (
    input  logic           ck,
    input  logic           rst,
    input  logic           ce,
    input  logic           clr_err,
    registro_fifo_if.slave bus,
    output logic           ovf,
    output logic           unf
);

    localparam int CW = clog2(DEPTH + 1);
    localparam int PW = clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             is_empty;
    logic             is_full;
    logic             wr_accept;
    logic             rd_adv;
    logic             ovf_set;
    logic             unf_set;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CW'(DEPTH));

    // A write is taken unless full in drop mode with no pop freeing a slot.
    // When full, wr_ptr == rd_ptr, so a write+pop overwrites the slot just popped.
    assign wr_accept = bus.wr & (~is_full | bus.rd | (MODE == MODE_OVERWRITE));

    // Head advances on a real pop, or when an overwrite pushes out the oldest word.
    assign rd_adv = (bus.rd & ~is_empty)
                  | (bus.wr & ~bus.rd & is_full & (MODE == MODE_OVERWRITE));

    assign ovf_set = bus.wr & ~bus.rd & is_full;
    assign unf_set = bus.rd & is_empty;

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        registro_n #(.WIDTH(WIDTH)) u_reg (
            .ck (ck),
            .en (ce & wr_accept & (wr_ptr == PW'(i))),
            .d  (bus.d),
            .q  (mem[i])
        );
    end

    // Pointer and occupancy update.
    always_ff @(posedge ck) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (ce) begin
            if (wr_accept) begin
                wr_ptr <= inc_ptr(wr_ptr);
            end
            if (rd_adv) begin
                rd_ptr <= inc_ptr(rd_ptr);
            end
            if (wr_accept && !rd_adv) begin
                cnt <= cnt + 1'b1;
            end else if (rd_adv && !wr_accept) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Sticky error flags; a new event on the clearing edge still sets the flag.
    always_ff @(posedge ck) begin
        if (rst) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (ce) begin
            ovf <= (ovf & ~clr_err) | ovf_set;
            unf <= (unf & ~clr_err) | unf_set;
        end
    end

    // Head-of-queue mux, zero when empty.
    always_comb begin
        head = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_ptr == PW'(i)) begin
                head = mem[i];
            end
        end
        if (is_empty) begin
            head = '0;
        end
    end

    assign bus.q     = head;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.count = cnt;

endmodule

// File: tb/tb_registro_fifo.sv
// Bench for registro_fifo: three instances (drop D=8, overwrite D=8, drop D=5)
// share stimulus lines and are selected one at a time through their ce.
// Expected pop data is queued per instance; monitors compare on each pop.
module tb_registro_fifo;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ce_v = 3'b000;
    logic       clr_err = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [3:0] d = 4'h0;
    logic       ovf0, unf0, ovf1, unf1, ovf2, unf2;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp0[$];
    logic [3:0] exp1[$];
    logic [3:0] exp2[$];

    always #5 ck = ~ck;

    registro_fifo_if #(.WIDTH(4), .DEPTH(8)) if0 ();
    registro_fifo_if #(.WIDTH(4), .DEPTH(8)) if1 ();
    registro_fifo_if #(.WIDTH(4), .DEPTH(5)) if2 ();

    assign if0.wr = wr;
    assign if0.rd = rd;
    assign if0.d  = d;
    assign if1.wr = wr;
    assign if1.rd = rd;
    assign if1.d  = d;
    assign if2.wr = wr;
    assign if2.rd = rd;
    assign if2.d  = d;

    registro_fifo #(.WIDTH(4), .DEPTH(8), .MODE(0)) u0 (
        .ck(ck), .rst(rst), .ce(ce_v[0]), .clr_err(clr_err),
        .bus(if0), .ovf(ovf0), .unf(unf0)
    );
    registro_fifo #(.WIDTH(4), .DEPTH(8), .MODE(1)) u1 (
        .ck(ck), .rst(rst), .ce(ce_v[1]), .clr_err(clr_err),
        .bus(if1), .ovf(ovf1), .unf(unf1)
    );
    registro_fifo #(.WIDTH(4), .DEPTH(5), .MODE(0)) u2 (
        .ck(ck), .rst(rst), .ce(ce_v[2]), .clr_err(clr_err),
        .bus(if2), .ovf(ovf2), .unf(unf2)
    );

    task automatic cmp(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; inputs change 1 time unit after the active edge.
    task automatic step(input logic w, input logic [3:0] dd, input logic r, input logic c);
        wr = w;
        d = dd;
        rd = r;
        clr_err = c;
        @(posedge ck);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        clr_err = 1'b0;
    endtask

    // Pop monitors: a pop is committed at the next edge, so compare the head now.
    always @(negedge ck) begin
        if (!rst && ce_v[0] && rd && !if0.empty) begin
            if (exp0.size() == 0) cmp("pop0_unexpected", int'(if0.q), -1);
            else cmp("pop0_data", int'(if0.q), int'(exp0.pop_front()));
        end
        if (!rst && ce_v[1] && rd && !if1.empty) begin
            if (exp1.size() == 0) cmp("pop1_unexpected", int'(if1.q), -1);
            else cmp("pop1_data", int'(if1.q), int'(exp1.pop_front()));
        end
        if (!rst && ce_v[2] && rd && !if2.empty) begin
            if (exp2.size() == 0) cmp("pop2_unexpected", int'(if2.q), -1);
            else cmp("pop2_data", int'(if2.q), int'(exp2.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        @(posedge ck);
        @(posedge ck);
        #1;
        rst = 1'b0;

        // Reset state of every instance
        cmp("rst_count0", int'(if0.count), 0);
        cmp("rst_empty0", int'(if0.empty), 1);
        cmp("rst_full0", int'(if0.full), 0);
        cmp("rst_q0", int'(if0.q), 0);
        cmp("rst_flags0", int'({ovf0, unf0}), 0);
        cmp("rst_count1", int'(if1.count), 0);
        cmp("rst_empty1", int'(if1.empty), 1);
        cmp("rst_count2", int'(if2.count), 0);
        cmp("rst_empty2", int'(if2.empty), 1);

        // Basic order on drop D=8
        ce_v = 3'b001;
        step(1'b1, 4'h3, 1'b0, 1'b0);
        cmp("fwft_q", int'(if0.q), 3);
        step(1'b1, 4'h7, 1'b0, 1'b0);
        step(1'b1, 4'hA, 1'b0, 1'b0);
        exp0.push_back(4'h3);
        exp0.push_back(4'h7);
        exp0.push_back(4'hA);
        cmp("t1_count3", int'(if0.count), 3);
        cmp("t1_q_head", int'(if0.q), 3);
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        cmp("t1_count0", int'(if0.count), 0);
        cmp("t1_empty", int'(if0.empty), 1);
        cmp("t1_q0", int'(if0.q), 0);

        // Drop policy: ninth push is lost
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 4'(i), 1'b0, 1'b0);
            if (i < 8) exp0.push_back(4'(i));
            if (i == 7) begin
                cmp("t2_full8", int'(if0.full), 1);
                cmp("t2_count8", int'(if0.count), 8);
                cmp("t2_ovf_before", int'(ovf0), 0);
            end
        end
        cmp("t2_ovf", int'(ovf0), 1);
        cmp("t2_count_hold", int'(if0.count), 8);
        cmp("t2_q_oldest", int'(if0.q), 0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        cmp("t2_empty", int'(if0.empty), 1);
        cmp("t2_ovf_sticky", int'(ovf0), 1);

        // Underflow, clear, simultaneous push+pop on empty
        step(1'b0, 4'h0, 1'b1, 1'b0);
        cmp("t5_unf", int'(unf0), 1);
        cmp("t5_count0", int'(if0.count), 0);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        cmp("t5_clr", int'({ovf0, unf0}), 0);
        step(1'b1, 4'h5, 1'b1, 1'b0);
        exp0.push_back(4'h5);
        cmp("t5_count1", int'(if0.count), 1);
        cmp("t5_q5", int'(if0.q), 5);
        cmp("t5_unf_wrrd", int'(unf0), 1);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        cmp("t5_clr_pop", int'(unf0), 0);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        cmp("t5_clr_vs_new", int'(unf0), 1);

        // Overwrite policy on D=8
        ce_v = 3'b010;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'(i), 1'b0, 1'b0);
            if (i >= 2) exp1.push_back(4'(i));
            if (i == 7) cmp("t3_ovf_before", int'(ovf1), 0);
        end
        cmp("t3_count8", int'(if1.count), 8);
        cmp("t3_ovf", int'(ovf1), 1);
        cmp("t3_q2", int'(if1.q), 2);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        cmp("t4_ovf_clr", int'(ovf1), 0);
        step(1'b1, 4'hF, 1'b1, 1'b0);
        exp1.push_back(4'hF);
        cmp("t4_count8", int'(if1.count), 8);
        cmp("t4_ovf0", int'(ovf1), 0);
        cmp("t4_q3", int'(if1.q), 3);
        for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        cmp("t4_empty", int'(if1.empty), 1);
        cmp("t4_unf0", int'(unf1), 0);

        // Non-power-of-2 depth: pointers wrap
        ce_v = 3'b100;
        for (int i = 1; i <= 9; i++) exp2.push_back(4'(i));
        for (int i = 1; i <= 3; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        for (int i = 4; i <= 12; i++) step(1'b1, 4'(i), 1'b1, 1'b0);
        cmp("t6_count3", int'(if2.count), 3);
        cmp("t6_qA", int'(if2.q), 10);
        ce_v = 3'b000;
        for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 1'b1, 1'b1);
        cmp("t6_ce_count", int'(if2.count), 3);
        cmp("t6_ce_q", int'(if2.q), 10);
        cmp("t6_ce_flags", int'({ovf2, unf2}), 0);
        ce_v = 3'b100;
        rst = 1'b1;
        step(1'b1, 4'hE, 1'b0, 1'b0);
        rst = 1'b0;
        cmp("t6_rst_count", int'(if2.count), 0);
        cmp("t6_rst_empty", int'(if2.empty), 1);
        cmp("t6_rst_q", int'(if2.q), 0);
        step(1'b1, 4'hD, 1'b0, 1'b0);
        exp2.push_back(4'hD);
        cmp("t6_post_q", int'(if2.q), 13);
        cmp("t6_post_count", int'(if2.count), 1);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        cmp("t6_final_empty", int'(if2.empty), 1);

        cmp("exp0_drained", exp0.size(), 0);
        cmp("exp1_drained", exp1.size(), 0);
        cmp("exp2_drained", exp2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
